// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/result interface: op codes, compare
// result codes and the driver state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [1:0] CMP_LT = 2'd1;
  localparam logic [1:0] CMP_EQ = 2'd2;
  localparam logic [1:0] CMP_GT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_EXEC,
    ST_CAPT,
    ST_READ,
    ST_RESP
  } drv_state_e;

  // Ops that only consume operand A.
  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_NOT) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_op_driver_settle_timer.sv
// Loadable down-counter timing the EXEC settle window; done_o is high while
// the count sits at zero.
module alu_op_driver_settle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_op_driver.sv
// Strobed ALU initiator: valid/ready request -> load A/B, settle, capture,
// valid/ready response. Optional feature macro: ALU_OP_DRIVER_UNARY_SKIP_EN.
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [WIDTH-1:0] alu_a0,
  output logic [WIDTH-1:0] alu_b0,
  output logic [2:0]       alu_sel,
  output logic             alu_init_a,
  output logic             alu_init_b,
  output logic             alu_init_y,
  input  logic [WIDTH-1:0] alu_y0,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned TW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  drv_state_e state_q, state_d;

  logic [WIDTH-1:0] a0_q, b0_q, rsp_y_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] ops_done_q;
  logic             init_a_q, init_b_q, init_y_q, rsp_valid_q;
  logic             accept, rsp_hs;
  logic             timer_load, timer_done;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign rsp_hs = (state_q == ST_RESP) && rsp_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_LOAD_A;
`ifdef ALU_OP_DRIVER_UNARY_SKIP_EN
      ST_LOAD_A: state_d = is_unary(sel_q) ? ST_EXEC : ST_LOAD_B;
`else
      ST_LOAD_A: state_d = ST_LOAD_B;
`endif
      ST_LOAD_B: state_d = ST_EXEC;
      ST_EXEC:   if (timer_done) state_d = ST_CAPT;
      ST_CAPT:   state_d = ST_READ;
      ST_READ:   state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign timer_load = (state_d == ST_EXEC) && (state_q != ST_EXEC);

  alu_op_driver_settle_timer #(
    .W (TW)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (SETTLE_LOAD),
    .done_o     (timer_done)
  );

  // Strobes and rsp_valid are decoded from the next state so each one is a
  // flop output aligned with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      init_a_q    <= 1'b0;
      init_b_q    <= 1'b0;
      init_y_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_a_q    <= (state_d == ST_LOAD_A);
      init_b_q    <= (state_d == ST_LOAD_B);
      init_y_q    <= (state_d == ST_CAPT);
      rsp_valid_q <= (state_d == ST_RESP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q       <= '0;
      b0_q       <= '0;
      sel_q      <= '0;
      rsp_y_q    <= '0;
      ops_done_q <= '0;
    end else begin
      if (accept) begin
        a0_q  <= req_a;
        sel_q <= req_op;
`ifdef ALU_OP_DRIVER_UNARY_SKIP_EN
        if (!is_unary(req_op)) b0_q <= req_b;
`else
        b0_q  <= req_b;
`endif
      end
      if (state_q == ST_READ) rsp_y_q <= alu_y0;
      if (rsp_hs) ops_done_q <= ops_done_q + CNT_W'(1);
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_y      = rsp_y_q;
  assign alu_a0     = a0_q;
  assign alu_b0     = b0_q;
  assign alu_sel    = sel_q;
  assign alu_init_a = init_a_q;
  assign alu_init_b = init_b_q;
  assign alu_init_y = init_y_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver with a behavioural ALU on the strobed
// side; honours ALU_OP_DRIVER_UNARY_SKIP_EN when defined.
module tb_alu_op_driver;

  localparam int S      = 1;
  localparam int TB_CNT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b, rsp_y, alu_a0, alu_b0, alu_y0;
  logic [2:0]  req_op, alu_sel;
  logic        alu_init_a, alu_init_b, alu_init_y, busy;
  logic [TB_CNT-1:0] ops_done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_done = 0;
  int overlap = 0;
  logic [31:0] prev_b = '0;

  always #5 clk = ~clk;

  alu_op_driver #(
    .WIDTH         (32),
    .SETTLE_CYCLES (S),
    .CNT_W         (TB_CNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .alu_a0     (alu_a0),
    .alu_b0     (alu_b0),
    .alu_sel    (alu_sel),
    .alu_init_a (alu_init_a),
    .alu_init_b (alu_init_b),
    .alu_init_y (alu_init_y),
    .alu_y0     (alu_y0),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return (a < b) ? 32'd1 : ((a == b) ? 32'd2 : 32'd3);
    endcase
  endfunction

  // Behavioural ALU: latches operands on their strobes, registers the result on init_y.
  logic [31:0] m_a, m_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; alu_y0 <= '0;
    end else begin
      if (alu_init_a) m_a <= alu_a0;
      if (alu_init_b) m_b <= alu_b0;
      if (alu_init_y) alu_y0 <= ref_alu(m_a, m_b, alu_sel);
    end
  end

  always @(negedge clk)
    if (!rst && (int'(alu_init_a) + int'(alu_init_b) + int'(alu_init_y)) > 1) overlap++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_init_a"}, 32'(alu_init_a), 32'd0);
    chk({tag, "_init_b"}, 32'(alu_init_b), 32'd0);
    chk({tag, "_init_y"}, 32'(alu_init_y), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ops_done"}, 32'(ops_done), 32'd0);
    chk({tag, "_rsp_y"}, rsp_y, 32'd0);
    chk({tag, "_alu_a0"}, alu_a0, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_idle_wait"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input int hold);
    int ka, kb, ky, kv, na, nb, ny, bad, lat;
    bit skip;
    logic [31:0] y_exp, y_seen;
    skip = 1'b0;
`ifdef ALU_OP_DRIVER_UNARY_SKIP_EN
    skip = (op == 3'b101) || (op == 3'b110);
`endif
    lat   = skip ? 3 + S : 4 + S;
    y_exp = ref_alu(a, b, op);
    wait_idle(tag);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; rsp_ready = 1'b0;
    @(posedge clk);
    ka = -1; kb = -1; ky = -1; kv = -1; na = 0; nb = 0; ny = 0; bad = 0;
    for (int i = 0; i < 40 && kv < 0; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      if (alu_init_a) begin na++; if (ka < 0) ka = i; end
      if (alu_init_b) begin nb++; if (kb < 0) kb = i; end
      if (alu_init_y) begin ny++; if (ky < 0) ky = i; end
      if (busy !== 1'b1 || req_ready !== 1'b0) bad++;
      if (rsp_valid) begin kv = i; rsp_ready = (hold == 0); end
    end
    if (kv < 0) begin
      chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      rsp_ready = 1'b0; req_valid = 1'b0;
      return;
    end
    chk({tag, "_latency"}, 32'(kv), 32'(lat));
    chk({tag, "_init_a_cnt"}, 32'(na), 32'd1);
    chk({tag, "_init_a_at"}, 32'(ka), 32'd0);
    chk({tag, "_init_b_cnt"}, 32'(nb), skip ? 32'd0 : 32'd1);
    if (!skip) chk({tag, "_init_b_at"}, 32'(kb), 32'd1);
    chk({tag, "_init_y_cnt"}, 32'(ny), 32'd1);
    chk({tag, "_init_y_at"}, 32'(ky), 32'(lat - 2));
    chk({tag, "_busy_ready"}, 32'(bad), 32'd0);
    chk({tag, "_rsp_y"}, rsp_y, y_exp);
    chk({tag, "_alu_a0"}, alu_a0, a);
    chk({tag, "_alu_b0"}, alu_b0, skip ? prev_b : b);
    chk({tag, "_alu_sel"}, 32'(alu_sel), 32'(op));
    y_seen = rsp_y;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_y"}, rsp_y, y_seen);
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      rsp_ready = (h == hold - 1);
    end
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    exp_done++;
    chk({tag, "_after_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_after_idle"}, 32'(req_ready), 32'd1);
    chk({tag, "_ops_done"}, 32'(ops_done), 32'(exp_done % (1 << TB_CNT)));
    chk({tag, "_a0_stable"}, alu_a0, a);
    if (!skip) prev_b = b;
  endtask

  task automatic reset_at(input string tag, input int at_k);
    wait_idle(tag);
    req_valid = 1'b1; req_a = 32'd1; req_b = 32'd2; req_op = 3'b000;
    @(posedge clk);
    for (int i = 0; i <= at_k; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    if (at_k == 0) chk({tag, "_pre_init_a"}, 32'(alu_init_a), 32'd1);
    else           chk({tag, "_pre_busy"}, 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset_state(tag);
    @(negedge clk);
    rst = 1'b0;
    exp_done = 0;
    prev_b = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    #2 chk_reset_state("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("add",     32'd5, 32'd7, 3'b000, 0);
    do_op("cmp_eq",  32'd3, 32'd3, 3'b111, 0);
    do_op("cmp_gt",  32'd9, 32'd4, 3'b111, 0);
    do_op("cmp_lt",  32'd0, 32'd1, 3'b111, 0);
    do_op("sub_bp",  32'd10, 32'd3, 3'b001, 8);
    do_op("not",     32'h0000FFFF, 32'h12345678, 3'b101, 0);
    do_op("shl",     32'h80000001, 32'h0, 3'b110, 1);
    reset_at("rst_load_a", 0);
    do_op("add2",    32'hFFFFFFFF, 32'd1, 3'b000, 0);
    reset_at("rst_exec", 2);

    for (int n = 0; n < 34; n++) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      op = 3'($urandom_range(0, 7));
      do_op("rand", a, b, op, $urandom_range(0, 3));
    end

    chk("strobe_overlap", 32'(overlap), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
